id_stage: RTL and testbench

Instruction-decode stage of the in-order RV32I pipeline. It sits between the fetch stage and execute, and drives the register file's read selects. It aligns the file's one-cycle registered read data with the held instruction, and bypasses same-edge writeback writes that the file's read port misses. Output is a valid/ready ID/EX interface carrying operands, decoded immediate and register indices.

---
 rtl/id_stage.sv | 83 ++++++++
 tb/tb_id_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// id_stage: RV32I decode stage holding one instruction, driving register-file selects and forwarding same-edge writeback into the ID/EX operands
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_inst,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  output logic [4:0]  rs1_s,
  output logic [4:0]  rs2_s,
  input  logic [31:0] rs1_v,
  input  logic [31:0] rs2_v,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd_s,
  input  logic [31:0] wb_rd_v,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_inst,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_rs1_s,
  output logic [4:0]  ex_rs2_s,
  output logic [4:0]  ex_rd_s,
  output logic [31:0] ex_rs1_v,
  output logic [31:0] ex_rs2_v,
  output logic [31:0] ex_imm
);
  localparam logic [31:0] NOP = 32'h00000013;
  logic        hold_valid;
  logic [31:0] hold_inst;
  logic [31:0] hold_pc;
  logic        byp1;
  logic        byp2;
  logic [31:0] byp1_v;
  logic [31:0] byp2_v;
  logic        can_cap;
  logic        cap;
  logic [6:0]  op;
  logic [31:0] i;
  assign id_ready = !hold_valid || ex_ready;
  assign can_cap  = if_valid && id_ready;
  assign cap      = can_cap && !flush;
  assign rs1_s    = can_cap ? if_inst[19:15] : hold_inst[19:15];
  assign rs2_s    = can_cap ? if_inst[24:20] : hold_inst[24:20];
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid <= 1'b0;
      hold_inst  <= NOP;
      hold_pc    <= '0;
      byp1       <= 1'b0;
      byp2       <= 1'b0;
    end else begin
      hold_valid <= !flush && (cap || (hold_valid && !ex_ready));
      if (cap) begin
        hold_inst <= if_inst;
        hold_pc   <= if_pc;
      end
      byp1 <= wb_we && wb_rd_s != 5'd0 && wb_rd_s == rs1_s;
      byp2 <= wb_we && wb_rd_s != 5'd0 && wb_rd_s == rs2_s;
    end
  end
  always_ff @(posedge clk) begin
    byp1_v <= wb_rd_v;
    byp2_v <= wb_rd_v;
  end
  assign ex_valid = hold_valid;
  assign ex_inst  = hold_inst;
  assign ex_pc    = hold_pc;
  assign ex_rs1_s = hold_inst[19:15];
  assign ex_rs2_s = hold_inst[24:20];
  assign ex_rd_s  = hold_inst[11:7];
  assign ex_rs1_v = byp1 ? byp1_v : rs1_v;
  assign ex_rs2_v = byp2 ? byp2_v : rs2_v;
  assign i        = hold_inst;
  assign op       = hold_inst[6:0];
  always_comb
    ex_imm = (op == 7'b0010011 || op == 7'b0000011 || op == 7'b1100111) ? {{20{i[31]}}, i[31:20]} :
             (op == 7'b0100011) ? {{20{i[31]}}, i[31:25], i[11:7]} :
             (op == 7'b1100011) ? {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0} :
             (op == 7'b0110111 || op == 7'b0010111) ? {i[31:12], 12'b0} :
             (op == 7'b1101111) ? {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0} :
             32'd0;
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed bench with a register-file model, an architectural reference model and hand-computed checks for id_stage
module tb_id_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] if_inst = 32'h00000013;
  logic [31:0] if_pc = '0;
  logic        id_ready;
  logic [4:0]  rs1_s;
  logic [4:0]  rs2_s;
  logic [31:0] rs1_v;
  logic [31:0] rs2_v;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_rd_s = '0;
  logic [31:0] wb_rd_v = '0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b1;
  logic        ex_valid;
  logic [31:0] ex_inst;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1_s;
  logic [4:0]  ex_rs2_s;
  logic [4:0]  ex_rd_s;
  logic [31:0] ex_rs1_v;
  logic [31:0] ex_rs2_v;
  logic [31:0] ex_imm;
  int checks = 0;
  int errors = 0;
  logic checking = 1'b0;
  logic [31:0] rf [32];
  logic        m_valid = 1'b0;
  logic [31:0] m_inst = 32'h00000013;
  logic [31:0] m_pc = '0;

  id_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc),
    .id_ready(id_ready), .rs1_s(rs1_s), .rs2_s(rs2_s), .rs1_v(rs1_v), .rs2_v(rs2_v),
    .wb_we(wb_we), .wb_rd_s(wb_rd_s), .wb_rd_v(wb_rd_v), .flush(flush), .ex_ready(ex_ready),
    .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc), .ex_rs1_s(ex_rs1_s),
    .ex_rs2_s(ex_rs2_s), .ex_rd_s(ex_rd_s), .ex_rs1_v(ex_rs1_v), .ex_rs2_v(ex_rs2_v),
    .ex_imm(ex_imm)
  );

  always #5 clk = ~clk;

  initial for (int k = 0; k < 32; k++) rf[k] = '0;

  always @(posedge clk) begin
    rs1_v <= rf[rs1_s];
    rs2_v <= rf[rs2_s];
    if (wb_we && wb_rd_s != 5'd0) rf[wb_rd_s] <= wb_rd_v;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_inst  = 32'h00000013;
      m_pc    = '0;
    end else if (flush) m_valid = 1'b0;
    else if (if_valid && (!m_valid || ex_ready)) begin
      m_valid = 1'b1;
      m_inst  = if_inst;
      m_pc    = if_pc;
    end else if (ex_ready) m_valid = 1'b0;
  end

  function automatic logic [31:0] imm_of(input logic [31:0] x);
    logic [31:0] r;
    case (x[6:0])
      7'b0010011, 7'b0000011, 7'b1100111: r = 32'($signed(x[31:20]));
      7'b0100011: r = 32'($signed({x[31:25], x[11:7]}));
      7'b1100011: r = 32'($signed({x[31], x[7], x[30:25], x[11:8], 1'b0}));
      7'b0110111, 7'b0010111: r = {x[31:12], 12'h000};
      7'b1101111: r = 32'($signed({x[31], x[19:12], x[20], x[30:21], 1'b0}));
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h", n, $time, a, e);
    end
  endtask

  always @(negedge clk) if (checking) begin
    chk("m_valid", 32'(ex_valid), 32'(m_valid));
    chk("m_id_ready", 32'(id_ready), 32'(!m_valid || ex_ready));
    chk("m_inst", ex_inst, m_inst);
    chk("m_pc", ex_pc, m_pc);
    chk("m_rs1_s", 32'(ex_rs1_s), 32'(m_inst[19:15]));
    chk("m_rs2_s", 32'(ex_rs2_s), 32'(m_inst[24:20]));
    chk("m_rd_s", 32'(ex_rd_s), 32'(m_inst[11:7]));
    chk("m_imm", ex_imm, imm_of(m_inst));
    if (m_valid) begin
      chk("m_rs1_v", ex_rs1_v, rf[m_inst[19:15]]);
      chk("m_rs2_v", ex_rs2_v, rf[m_inst[24:20]]);
    end
  end

  task automatic step(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                      input logic er, input logic fl, input logic we,
                      input logic [4:0] rd, input logic [31:0] v);
    if_valid = iv;
    if_inst  = inst;
    if_pc    = pc;
    ex_ready = er;
    flush    = fl;
    wb_we    = we;
    wb_rd_s  = rd;
    wb_rd_v  = v;
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    step(0, 32'h13, 0, 1, 0, 0, 0, 0);
    step(0, 32'h13, 0, 1, 0, 0, 0, 0);
    checking = 1'b1;
    rst = 1'b0;
    step(0, 32'h13, 0, 1, 0, 0, 0, 0);
    chk("rst_valid", 32'(ex_valid), 32'd0);
    chk("rst_inst", ex_inst, 32'h00000013);
    chk("rst_ready", 32'(id_ready), 32'd1);
    chk("rst_imm", ex_imm, 32'd0);
    step(0, 32'h13, 0, 1, 0, 1, 5'd1, 32'd5);
    step(0, 32'h13, 0, 1, 0, 1, 5'd2, 32'd7);
    step(1, 32'h002081B3, 32'h1000, 1, 0, 0, 0, 0);
    chk("pass_valid", 32'(ex_valid), 32'd1);
    chk("pass_rs1_v", ex_rs1_v, 32'd5);
    chk("pass_rs2_v", ex_rs2_v, 32'd7);
    chk("pass_rd", 32'(ex_rd_s), 32'd3);
    chk("pass_pc", ex_pc, 32'h1000);
    step(1, 32'hFFF08213, 32'h1004, 1, 0, 1, 5'd1, 32'hDEAD);
    chk("byp_rs1_v", ex_rs1_v, 32'hDEAD);
    chk("byp_imm", ex_imm, 32'hFFFFFFFF);
    step(1, 32'h002081B3, 32'h1008, 1, 0, 0, 0, 0);
    step(1, 32'h00000013, 32'h100C, 0, 0, 0, 0, 0);
    chk("stall1_ready", 32'(id_ready), 32'd0);
    chk("stall1_inst", ex_inst, 32'h002081B3);
    chk("stall1_rs2_v", ex_rs2_v, 32'd7);
    step(1, 32'h00000013, 32'h100C, 0, 0, 1, 5'd2, 32'd9);
    chk("stall2_ready", 32'(id_ready), 32'd0);
    chk("stall2_rs2_v", ex_rs2_v, 32'd9);
    step(1, 32'h00000013, 32'h100C, 0, 0, 0, 0, 0);
    chk("stall3_ready", 32'(id_ready), 32'd0);
    chk("stall3_inst", ex_inst, 32'h002081B3);
    chk("stall3_rs1_v", ex_rs1_v, 32'hDEAD);
    chk("stall3_rs2_v", ex_rs2_v, 32'd9);
    step(1, 32'h00500293, 32'h2000, 0, 1, 0, 0, 0);
    chk("flush_valid", 32'(ex_valid), 32'd0);
    chk("flush_inst", ex_inst, 32'h002081B3);
    chk("flush_pc", ex_pc, 32'h1008);
    step(1, 32'h00300313, 32'h3000, 1, 0, 1, 5'd0, 32'h55);
    chk("x0_valid", 32'(ex_valid), 32'd1);
    chk("x0_rs1_v", ex_rs1_v, 32'd0);
    chk("x0_imm", ex_imm, 32'd3);
    step(1, 32'h008000EF, 32'h3004, 1, 0, 0, 0, 0);
    chk("jal_imm", ex_imm, 32'd8);
    chk("jal_rd", 32'(ex_rd_s), 32'd1);
    step(1, 32'hFE000EE3, 32'h3008, 1, 0, 0, 0, 0);
    chk("beq_imm", ex_imm, 32'hFFFFFFFC);
    step(1, 32'h0020A423, 32'h300C, 1, 0, 0, 0, 0);
    chk("sw_imm", ex_imm, 32'd8);
    step(1, 32'h123453B7, 32'h3010, 1, 0, 1, 5'd7, 32'h77);
    chk("lui_imm", ex_imm, 32'h12345000);
    step(1, 32'h00038413, 32'h3014, 1, 0, 0, 0, 0);
    chk("chain_rs1_v", ex_rs1_v, 32'h77);
    step(0, 32'h13, 0, 1, 0, 0, 0, 0);
    chk("drain_valid", 32'(ex_valid), 32'd0);
    step(1, 32'h002081B3, 32'h4000, 0, 0, 0, 0, 0);
    step(1, 32'h13, 32'h4004, 0, 0, 0, 0, 0);
    chk("hold_valid", 32'(ex_valid), 32'd1);
    rst = 1'b1;
    step(1, 32'h13, 32'h4004, 0, 0, 0, 0, 0);
    chk("mid_rst_valid", 32'(ex_valid), 32'd0);
    chk("mid_rst_inst", ex_inst, 32'h00000013);
    rst = 1'b0;
    step(0, 32'h13, 0, 1, 0, 0, 0, 0);
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
